mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port to one-port memory arbiter sitting directly downstream of the core datapath and upstream of the single unified word memory inside `core_top`. It accepts instruction-fetch and load/store requests from the datapath, serialises them onto the one memory port, and returns read data with a one-cycle acknowledge. Data accesses take priority over fetches so an in-flight load/store never deadlocks against the next fetch.

## Interface
- `ADDR_WIDTH`, 32, byte address width of both request ports and the memory port
- `DATA_WIDTH`, 32, word width; fixed at 32 (byte enables are 4 bits)

- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `i_req`  in  1  fetch request, held until `i_ack`
- `i_addr`  in  ADDR_WIDTH  fetch byte address
- `i_ack`  out  1  one-cycle fetch completion pulse
- `i_rdata`  out  DATA_WIDTH  fetched word, valid while `i_ack`=1
- `d_req`  in  1  data request, held until `d_ack`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_WIDTH  data byte address
- `d_wdata`  in  DATA_WIDTH  store data
- `d_be`  in  4  store byte enables
- `d_ack`  out  1  one-cycle data completion pulse
- `d_rdata`  out  DATA_WIDTH  load word, valid while `d_ack`=1
- `d_err`  out  1  misaligned-access flag, valid while `d_ack`=1
- `m_rd`  out  1  memory read strobe
- `m_wr`  out  1  memory write strobe
- `m_addr`  out  ADDR_WIDTH  word-aligned memory address (bits [1:0] always 0)
- `m_wdata`  out  DATA_WIDTH  memory write data
- `m_be`  out  4  memory byte enables
- `m_rdata`  in  DATA_WIDTH  memory read data, registered by memory one edge after `m_rd`

## Operation
- FSM states: IDLE, ACCESS, WAIT, RESP. Reset state IDLE.
- IDLE: at an edge with `d_req`=1, capture `d_*`, set owner=DATA, go ACCESS; else if `i_req`=1, capture `i_addr`, owner=FETCH, go ACCESS; else stay.
- Simultaneous `d_req` and `i_req` in IDLE: DATA wins; FETCH served on the next IDLE acceptance.
- ACCESS: exactly one of `m_rd` (fetch or load) / `m_wr` (store) high; `m_addr`={addr[ADDR_WIDTH-1:2],2'b00}; `m_be`=4'hF for reads, captured `d_be` for stores. Next state WAIT.
- WAIT: no strobes; memory presents `m_rdata`. At edge, capture `m_rdata` into owner's rdata register, go RESP.
- RESP: owner's ack = 1 for exactly this cycle; next state IDLE unconditionally (requests ignored in RESP, so a held-over `req` is not re-accepted).
- Stores also pass through WAIT/RESP; `d_rdata` on store ack is don't-care.
- Request inputs are only sampled in IDLE; changes during ACCESS/WAIT/RESP have no effect.
- Reset (any state, asynchronous): state IDLE; `m_rd`, `m_wr`, `i_ack`, `d_ack`, `d_err` = 0; `m_addr`, `m_wdata`, `m_be`, `i_rdata`, `d_rdata` = 0. Interrupted transaction is dropped, never acknowledged.

## Timing
- Acceptance edge E0. Strobe high E0–E1. Data captured E2; ack high E2–E3. IDLE again at E3; earliest next acceptance E4.
- Latency request-sampled to ack: 2 edges; throughput: one access per 4 cycles.
- All outputs registered; no combinational path from any input to any output.
- Requester drops `req` at the edge that samples `ack`=1.

## Configuration
- `MISALIGN_TRAP_EN` defined: a data request with `d_addr[1:0]`≠0 is accepted in IDLE, issues no memory strobe, goes ACCESS→RESP directly; `d_ack`=1 and `d_err`=1 for one cycle starting E1; IDLE at E2. Fetches never trap.
- Not defined: `d_addr[1:0]` ignored, access proceeds word-aligned; `d_err` tied 0.

## Test plan
- Fetch `i_addr`=0x10, memory word 4 = 0xDEADBEEF -> `m_rd` high E0–E1 with `m_addr`=0x10, `i_ack`=1 and `i_rdata`=0xDEADBEEF E2–E3.
- Store `d_addr`=0x10, `d_wdata`=0x12345678, `d_be`=4'hF -> `m_wr` one cycle, `d_ack` at E2, memory word 4 = 0x12345678; `m_rd` never high.
- `i_req` and `d_req` both raised before same edge (load 0x14) -> data served first (`d_ack` at E2), fetch accepted at E4, `i_ack` at E6.
- Held `req` through RESP -> exactly one ack per request, no duplicate strobe.
- `rst` pulsed during WAIT -> all outputs 0 within the reset cycle, no ack; subsequent fetch completes normally.
- `d_addr`=0x13 load -> with `MISALIGN_TRAP_EN`: `d_err`=`d_ack`=1 at E1, no strobe; without: `m_addr`=0x10, `d_err`=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises instruction-fetch and load/store requests onto a
// single word-wide memory port. Data requests win over fetches. Every access
// walks IDLE -> ACCESS -> WAIT -> RESP and returns a one-cycle acknowledge.
//
// Optional feature: define MISALIGN_TRAP_EN to trap data requests whose byte
// address is not word aligned. A trapped request issues no memory strobe and
// is acknowledged with d_err one cycle after acceptance. When the macro is
// left undefined, the low address bits are ignored and d_err is always 0.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_ack,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [3:0]            d_be,
    output logic                  d_ack,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_err,
    output logic                  m_rd,
    output logic                  m_wr,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    output logic [3:0]            m_be,
    input  logic [DATA_WIDTH-1:0] m_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t state;
    state_t state_nxt;
    logic   owner_data;
    logic   we_q;
    logic   trap_q;
    logic   unused_addr_bits;

    // The two low address bits never reach the memory port.
    assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

`ifndef MISALIGN_TRAP_EN
    assign trap_q = 1'b0;
`endif

    // State register plus the request capture and read-data return registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner_data <= 1'b0;
            we_q       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_be       <= 4'h0;
            i_rdata    <= '0;
            d_rdata    <= '0;
`ifdef MISALIGN_TRAP_EN
            trap_q     <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                if (d_req) begin
                    owner_data <= 1'b1;
                    we_q       <= d_we;
                    m_addr     <= {d_addr[ADDR_WIDTH-1:2], 2'b00};
                    m_wdata    <= d_wdata;
                    m_be       <= d_we ? d_be : 4'hF;
`ifdef MISALIGN_TRAP_EN
                    trap_q     <= (d_addr[1:0] != 2'b00);
`endif
                end else if (i_req) begin
                    owner_data <= 1'b0;
                    we_q       <= 1'b0;
                    m_addr     <= {i_addr[ADDR_WIDTH-1:2], 2'b00};
                    m_be       <= 4'hF;
`ifdef MISALIGN_TRAP_EN
                    trap_q     <= 1'b0;
`endif
                end
            end
            if (state == WAIT) begin
                if (owner_data) begin
                    d_rdata <= m_rdata;
                end else begin
                    i_rdata <= m_rdata;
                end
            end
        end
    end

    // Next-state logic; requests are looked at only while idle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (d_req || i_req) state_nxt = ACCESS;
            ACCESS:  state_nxt = trap_q ? RESP : WAIT;
            WAIT:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes and acknowledges decoded purely from registered state.
    always_comb begin
        m_rd  = 1'b0;
        m_wr  = 1'b0;
        i_ack = 1'b0;
        d_ack = 1'b0;
        d_err = 1'b0;
        if (state == ACCESS && !trap_q) begin
            m_wr = owner_data && we_q;
            m_rd = !(owner_data && we_q);
        end
        if (state == RESP) begin
            i_ack = !owner_data;
            d_ack = owner_data;
            d_err = owner_data && trap_q;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a small
// registered word memory model attached to the memory port.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_be = 4'h0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        m_rd;
    logic        m_wr;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic [31:0] m_rdata = '0;
    logic        preload = 1'b1;
    logic [31:0] mem [0:15];

    int n_checks = 0;
    int n_fail = 0;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_be(d_be), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .m_rd(m_rd), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_be(m_be), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: read data registered one edge after m_rd, byte-enabled writes.
    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < 16; k++) mem[k] <= 32'h0;
            mem[4] <= 32'hDEADBEEF;
            mem[5] <= 32'hCAFEF00D;
            mem[6] <= 32'h0BADF00D;
            mem[7] <= 32'h11223344;
        end else begin
            if (m_rd) m_rdata <= mem[m_addr[5:2]];
            if (m_wr) begin
                for (int b = 0; b < 4; b++)
                    if (m_be[b]) mem[m_addr[5:2]][8*b +: 8] <= m_wdata[8*b +: 8];
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        tick();
        tick();
        n_checks++; if ({m_rd, m_wr, i_ack, d_ack, d_err} !== 5'b0) begin n_fail++; $display("[TB] FAIL reset_ctrl: got %b want 00000", {m_rd, m_wr, i_ack, d_ack, d_err}); end
        n_checks++; if ({m_addr, m_wdata, m_be, i_rdata, d_rdata} !== 132'h0) begin n_fail++; $display("[TB] FAIL reset_data: got %h want 0", {m_addr, m_wdata, m_be, i_rdata, d_rdata}); end
        preload = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fetch;
        i_req = 1'b1; i_addr = 32'h10;
        tick();  // E0
        n_checks++; if ({m_rd, m_wr} !== 2'b10) begin n_fail++; $display("[TB] FAIL fetch_strobe: got %b want 10", {m_rd, m_wr}); end
        n_checks++; if (m_addr !== 32'h10) begin n_fail++; $display("[TB] FAIL fetch_m_addr: got %h want 00000010", m_addr); end
        n_checks++; if (m_be !== 4'hF) begin n_fail++; $display("[TB] FAIL fetch_m_be: got %h want f", m_be); end
        tick();  // E1
        n_checks++; if ({m_rd, m_wr, i_ack} !== 3'b000) begin n_fail++; $display("[TB] FAIL fetch_wait: got %b want 000", {m_rd, m_wr, i_ack}); end
        tick();  // E2
        n_checks++; if ({i_ack, d_ack} !== 2'b10) begin n_fail++; $display("[TB] FAIL fetch_ack: got %b want 10", {i_ack, d_ack}); end
        n_checks++; if (i_rdata !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL fetch_rdata: got %h want deadbeef", i_rdata); end
        i_req = 1'b0;
        tick();  // E3
        n_checks++; if (i_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL fetch_ack_len: got %b want 0", i_ack); end
    endtask

    task automatic test_store;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'h12345678; d_be = 4'hF;
        tick();  // E0
        n_checks++; if ({m_rd, m_wr} !== 2'b01) begin n_fail++; $display("[TB] FAIL store_strobe: got %b want 01", {m_rd, m_wr}); end
        n_checks++; if ({m_addr, m_wdata, m_be} !== {32'h10, 32'h12345678, 4'hF}) begin n_fail++; $display("[TB] FAIL store_port: got %h want 00000010123456780f", {m_addr, m_wdata, m_be}); end
        tick();  // E1
        n_checks++; if ({m_rd, m_wr} !== 2'b00) begin n_fail++; $display("[TB] FAIL store_wait: got %b want 00", {m_rd, m_wr}); end
        tick();  // E2
        n_checks++; if ({d_ack, i_ack, m_rd, d_err} !== 4'b1000) begin n_fail++; $display("[TB] FAIL store_ack: got %b want 1000", {d_ack, i_ack, m_rd, d_err}); end
        n_checks++; if (mem[4] !== 32'h12345678) begin n_fail++; $display("[TB] FAIL store_mem: got %h want 12345678", mem[4]); end
        d_req = 1'b0;
        tick();  // E3
    endtask

    task automatic test_partial_store;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1C; d_wdata = 32'hAABBCCDD; d_be = 4'b0011;
        tick();  // E0
        n_checks++; if ({m_wr, m_be} !== {1'b1, 4'b0011}) begin n_fail++; $display("[TB] FAIL pstore_be: got %b want 10011", {m_wr, m_be}); end
        tick();
        tick();  // E2
        n_checks++; if (mem[7] !== 32'h1122CCDD) begin n_fail++; $display("[TB] FAIL pstore_mem: got %h want 1122ccdd", mem[7]); end
        d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
        tick();
    endtask

    task automatic test_priority;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h14;
        i_req = 1'b1; i_addr = 32'h18;
        tick();  // E0
        n_checks++; if ({m_rd, m_addr} !== {1'b1, 32'h14}) begin n_fail++; $display("[TB] FAIL prio_first: got %b/%h want 1/00000014", m_rd, m_addr); end
        tick();
        tick();  // E2
        n_checks++; if ({d_ack, i_ack} !== 2'b10) begin n_fail++; $display("[TB] FAIL prio_dack: got %b want 10", {d_ack, i_ack}); end
        n_checks++; if (d_rdata !== 32'hCAFEF00D) begin n_fail++; $display("[TB] FAIL prio_drdata: got %h want cafef00d", d_rdata); end
        d_req = 1'b0;
        tick();  // E3
        n_checks++; if ({m_rd, i_ack, d_ack} !== 3'b000) begin n_fail++; $display("[TB] FAIL prio_gap: got %b want 000", {m_rd, i_ack, d_ack}); end
        tick();  // E4
        n_checks++; if ({m_rd, m_addr} !== {1'b1, 32'h18}) begin n_fail++; $display("[TB] FAIL prio_second: got %b/%h want 1/00000018", m_rd, m_addr); end
        tick();
        tick();  // E6
        n_checks++; if ({i_ack, d_ack, i_rdata} !== {2'b10, 32'h0BADF00D}) begin n_fail++; $display("[TB] FAIL prio_iack: got %b/%h want 10/0badf00d", {i_ack, d_ack}, i_rdata); end
        i_req = 1'b0;
        tick();
    endtask

    task automatic test_held_req;
        i_req = 1'b1; i_addr = 32'h14;
        tick();
        tick();
        tick();  // E2
        n_checks++; if ({i_ack, i_rdata} !== {1'b1, 32'hCAFEF00D}) begin n_fail++; $display("[TB] FAIL held_ack: got %b/%h want 1/cafef00d", i_ack, i_rdata); end
        tick();  // E3, request still high
        n_checks++; if ({i_ack, m_rd} !== 2'b00) begin n_fail++; $display("[TB] FAIL held_resp_exit: got %b want 00", {i_ack, m_rd}); end
        i_req = 1'b0;
        tick();  // E4
        n_checks++; if ({m_rd, i_ack} !== 2'b00) begin n_fail++; $display("[TB] FAIL held_no_dup: got %b want 00", {m_rd, i_ack}); end
        tick();
    endtask

    task automatic test_reset_in_wait;
        int acks;
        i_req = 1'b1; i_addr = 32'h18;
        tick();  // E0
        tick();  // E1, WAIT
        rst = 1'b1;
        i_req = 1'b0;
        #1;
        n_checks++; if ({m_rd, m_wr, i_ack, d_ack, d_err} !== 5'b0) begin n_fail++; $display("[TB] FAIL rstw_ctrl: got %b want 00000", {m_rd, m_wr, i_ack, d_ack, d_err}); end
        n_checks++; if ({m_addr, m_be, i_rdata, d_rdata} !== 100'h0) begin n_fail++; $display("[TB] FAIL rstw_data: got %h want 0", {m_addr, m_be, i_rdata, d_rdata}); end
        acks = 0;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (i_ack || d_ack) acks++;
            tick();
        end
        n_checks++; if (acks !== 0) begin n_fail++; $display("[TB] FAIL rstw_dropped: got %0d acks want 0", acks); end
        i_req = 1'b1; i_addr = 32'h10;
        tick();
        tick();
        tick();  // E2
        n_checks++; if ({i_ack, i_rdata} !== {1'b1, 32'h12345678}) begin n_fail++; $display("[TB] FAIL rstw_after: got %b/%h want 1/12345678", i_ack, i_rdata); end
        i_req = 1'b0;
        tick();
    endtask

    task automatic test_misalign;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h13;
        tick();  // E0
`ifdef MISALIGN_TRAP_EN
        n_checks++; if ({m_rd, m_wr} !== 2'b00) begin n_fail++; $display("[TB] FAIL mis_no_strobe: got %b want 00", {m_rd, m_wr}); end
        tick();  // E1
        n_checks++; if ({d_ack, d_err} !== 2'b11) begin n_fail++; $display("[TB] FAIL mis_trap: got %b want 11", {d_ack, d_err}); end
        d_req = 1'b0;
        tick();  // E2
        n_checks++; if ({d_ack, d_err, m_rd} !== 3'b000) begin n_fail++; $display("[TB] FAIL mis_idle: got %b want 000", {d_ack, d_err, m_rd}); end
`else
        n_checks++; if ({m_rd, m_addr} !== {1'b1, 32'h10}) begin n_fail++; $display("[TB] FAIL mis_aligned: got %b/%h want 1/00000010", m_rd, m_addr); end
        tick();
        tick();  // E2
        n_checks++; if ({d_ack, d_err, d_rdata} !== {2'b10, 32'h12345678}) begin n_fail++; $display("[TB] FAIL mis_ack: got %b/%h want 10/12345678", {d_ack, d_err}, d_rdata); end
        d_req = 1'b0;
        tick();
`endif
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_partial_store();
        test_priority();
        test_held_req();
        test_reset_in_wait();
        test_misalign();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
